// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one outstanding imem request at a time from the PC and
// queues returned instructions with their PCs for decode.
module instr_fetch_unit #(
  parameter int WIDTH   = 32,
  parameter int IWIDTH  = 32,
  parameter int DEPTH   = 2,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  pc,
  output logic              pc_advance,
  input  logic              redirect,
  output logic              imem_req,
  output logic [WIDTH-1:0]  imem_addr,
  input  logic              imem_ack,
  input  logic [IWIDTH-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IWIDTH-1:0] out_instr,
  output logic [WIDTH-1:0]  out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  typedef struct packed {
    logic [WIDTH-1:0]  pc;
    logic [IWIDTH-1:0] instr;
  } entry_t;

  state_t           state;
  logic [WIDTH-1:0] addr_q;
  logic [CW-1:0]    count, count_next;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  entry_t           fifo [DEPTH];
  logic             push, pop;

  assign imem_req   = (state == REQ) || (state == DRAIN);
  assign imem_addr  = addr_q;
  assign pc_advance = (state == REQ) && imem_ack && !redirect;
  assign push       = pc_advance;
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready && !redirect;
  assign out_instr  = fifo[rd_ptr].instr;
  assign out_pc     = fifo[rd_ptr].pc;

  // push never happens at FULL, so this cannot overflow
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      addr_q <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!redirect && (count < FULL)) begin
            addr_q <= pc;
            state  <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (!redirect && (count_next < FULL)) addr_q <= addr_q + WIDTH'(PC_STEP);
            else                                  state  <= IDLE;
          end else if (redirect) begin
            // memory cannot abort: wait out the stale response
            state <= DRAIN;
          end
        end
        DRAIN:   if (imem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= '{pc: addr_q, instr: imem_rdata};
          wr_ptr       <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count_next;
      end
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the PC register.
- Takes the registered PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned instructions with their PCs in a small FIFO for decode.
- Pulses pc_advance so the PC register loads PC+PC_STEP only when a fetch completes; flushes on branch/jump redirect.

Parameters:
- WIDTH, 32, address/PC width.
- IWIDTH, 32, instruction width.
- DEPTH, 2, instruction buffer entries (power of 2, >= 2).
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- pc  in  WIDTH  current PC from the PC register.
- pc_advance  out  1  1 = PC register loads next sequential PC this edge.
- redirect  in  1  branch/jump taken; PC register loads the target this edge.
- imem_req  out  1  memory request valid.
- imem_addr  out  WIDTH  request address; stable while imem_req=1.
- imem_ack  in  1  memory response strobe, single cycle.
- imem_rdata  in  IWIDTH  instruction; valid when imem_ack=1.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  IWIDTH  head instruction.
- out_pc  out  WIDTH  PC of head instruction.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; count, wr_ptr, rd_ptr = 0; addr_q=0; buffer contents=0.
  - Outputs: imem_req=0, imem_addr=0, out_valid=0, out_instr=0, out_pc=0, pc_advance=0.
- FSM states: IDLE, REQ, DRAIN.
  - imem_req = (state==REQ) or (state==DRAIN).
  - imem_addr = addr_q.
- IDLE:
  - If !redirect and count<DEPTH: addr_q<=pc, go to REQ.
  - Else stay in IDLE.
- REQ:
  - Hold request until imem_ack.
  - On ack with !redirect:
    - Push {addr_q, imem_rdata}; pc_advance=1 (combinational, same cycle).
    - If post-update count<DEPTH: addr_q<=addr_q+PC_STEP and stay in REQ (back-to-back, 1 fetch/cycle at zero-wait memory).
    - Else go to IDLE.
  - On redirect without ack: go to DRAIN.
  - On redirect with ack: discard data, no push, pc_advance=0, go to IDLE.
- DRAIN:
  - Request held, since the memory protocol forbids abort.
  - On imem_ack: discard data, go to IDLE.
  - A redirect while in DRAIN has no additional effect.
- pc_advance = (state==REQ) & imem_ack & !redirect; never asserted in IDLE or DRAIN.
- Addresses wrap modulo 2^WIDTH; no fault is raised on wrap.
- Buffer:
  - out_valid = (count!=0); out_instr/out_pc driven from the rd_ptr entry.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
  - A push never occurs at count==DEPTH, because issue is gated by count<DEPTH and at most one request is outstanding.
- redirect (highest priority): count, wr_ptr, rd_ptr <= 0 on that edge; any pop or push in that cycle is cancelled. out_valid=0 the next cycle.
- Latency: PC sampled in IDLE → imem_req next cycle → entry visible at out_valid the cycle after ack.
- Reset asserted mid-request drops imem_req immediately; the memory must tolerate this.

Test Plan:
- Zero-wait memory (ack same cycle as req), out_ready=1, reset release with pc=0x0 → after IDLE cycle, imem_addr 0x0,0x4,0x8 on consecutive cycles; pc_advance high each ack; out_pc follows 0x0,0x4,0x8 one cycle behind, with matching out_instr.
- out_ready=0, DEPTH=2, zero-wait → exactly two pushes (0x0,0x4), then state IDLE and imem_req=0; raise out_ready → pops 0x0, then fetch of 0x8 resumes.
- 3-cycle ack latency → imem_req and imem_addr=0x10 held stable 3 cycles; single pc_advance pulse on the ack cycle; no push before ack.
- Redirect one cycle after req issue, ack two cycles later → DRAIN entered, returned data not pushed, pc_advance stays 0, count=0; next request uses new pc=0x100.
- Redirect coinciding with ack and with pop at count=2 → count=0, no push/pop, pc_advance=0, out_valid=0 next cycle.
- Reset driven low mid-REQ with count=1 → imem_req, out_valid, out_instr, out_pc all 0 immediately, before the next clk edge; normal fetch from current pc after release.
